input_debouncer: RTL
====================

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop count, legal range >=2.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a change, legal range >=1.
REQ-003 SHALL have parameter RESET_VALUE (logic), default 0: reset level of the synchronizer chain, FSM and level_o.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic is in this domain.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port async_i, input, 1: raw asynchronous, possibly bouncing level, for example a pad or switch.
REQ-007 SHALL have port enable_i, input, 1: debounce enable; when low, the FSM is frozen in its stable state.
REQ-008 SHALL have port level_o, output, 1: registered, debounced level; drives the downstream edge/toggle detection.
REQ-009 SHALL have port busy_o, output, 1: high while a candidate change is being qualified.
REQ-010 SHALL have port glitch_count_o, output, 8: rejected-glitch count; present only under INPUT_DEBOUNCER_GLITCH_CNT_EN.

Function
REQ-011 SHALL pass async_i through a SYNC_STAGES-deep flop chain; only the last stage (sync_q) feeds the FSM.
REQ-012 SHALL implement the FSM states ST_LOW, ST_RISE, ST_HIGH and ST_FALL, with counter cnt of width $clog2(DEBOUNCE_CYCLES+1).
REQ-013 SHALL, in ST_LOW with enable_i=1 and sync_q=1, move to ST_RISE with cnt=0; ST_HIGH with sync_q=0 SHALL move to ST_FALL symmetrically.
REQ-014 SHALL, in ST_RISE with sync_q=1, set level_o=1 and move to ST_HIGH on the same edge if cnt==DEBOUNCE_CYCLES-1, and otherwise increment cnt; ST_FALL SHALL behave symmetrically, clearing level_o and moving to ST_LOW.
REQ-015 SHALL, in ST_RISE with sync_q=0, return to ST_LOW with cnt=0 and count one glitch; ST_FALL with sync_q=1 SHALL return to ST_HIGH symmetrically.
REQ-016 SHALL change level_o no earlier than SYNC_STAGES+DEBOUNCE_CYCLES+1 rising edges after async_i settles, counting the first edge that samples the new value; with defaults this is 19 edges.
REQ-017 SHALL keep level_o glitch-free: it changes only in the ST_RISE->ST_HIGH and ST_FALL->ST_LOW transitions.
REQ-018 SHALL drive busy_o = (state==ST_RISE || state==ST_FALL), decoded from the state register only.
REQ-019 SHALL, when enable_i=0, force the next state to the stable state matching level_o (ST_RISE->ST_LOW, ST_FALL->ST_HIGH), clear cnt, keep level_o unchanged and count no glitch; the synchronizer keeps running.
REQ-020 SHALL, after enable_i returns high, start any qualification from cnt=0 (no partial credit).
REQ-021 SHALL give rst_i priority over enable_i and every FSM transition.

Reset
REQ-022 SHALL, while rst_i=1 at a clock edge, load every sync flop with RESET_VALUE.
REQ-023 SHALL, on the same reset edge, set the FSM to ST_HIGH if RESET_VALUE=1 and to ST_LOW otherwise.
REQ-024 SHALL, on the same reset edge, set level_o=RESET_VALUE, busy_o=0, cnt=0 and glitch_count_o=0.
REQ-025 SHALL, on reset during ST_RISE or ST_FALL, abandon the qualification; no level_o change results from it.

Configuration
REQ-026 SHALL, with INPUT_DEBOUNCER_GLITCH_CNT_EN defined, provide an 8-bit glitch_count_o incremented per REQ-015 and saturating at 255.
REQ-027 SHALL, without INPUT_DEBOUNCER_GLITCH_CNT_EN, omit the glitch_count_o port and its counter entirely; all other behaviour is identical.

Structure
REQ-028 SHALL place the state enum typedef (debounce_state_e) and GLITCH_CNT_W=8 in shared package debounce_pkg.
REQ-029 SHALL implement the synchronizer chain as sub-module bit_synchronizer (parameters STAGES and RESET_VALUE; same clk_i/rst_i), reusable elsewhere.

Verification
REQ-030 SHALL cover reset: RESET_VALUE=0, async_i=1 held through 5 reset cycles -> level_o=0, busy_o=0, glitch_count_o=0 while reset is high.
REQ-031 SHALL cover a clean rise: defaults, async_i 0->1 held 40 cycles -> level_o=1 on edge 19 exactly, busy_o high for 16 cycles.
REQ-032 SHALL cover a glitch: async_i high for 5 cycles, then low -> level_o stays 0, glitch_count_o=1, busy_o returns to 0.
REQ-033 SHALL cover enable drop: enable_i=0 at cnt=10 in ST_RISE -> busy_o=0 next edge, level_o=0; enable_i=1 again -> level_o=1 exactly 16 edges later.
REQ-034 SHALL cover saturation: 300 short glitches -> glitch_count_o=255 with no wrap.
REQ-035 SHALL cover the minimum counter and reset mid-count: DEBOUNCE_CYCLES=1 -> level_o=1 on edge 4; rst_i pulse at cnt=8 -> level_o=RESET_VALUE and a full 19-edge requalification.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types for the input debouncer: FSM state encoding and glitch counter width.
package debounce_pkg;

  localparam int GLITCH_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_RISE = 2'd1,
    ST_HIGH = 2'd2,
    ST_FALL = 2'd3
  } debounce_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last stage.
module bit_synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= {STAGES{RESET_VALUE}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw level; a change is accepted after DEBOUNCE_CYCLES stable cycles.
// Optional rejected-glitch counter port enabled by INPUT_DEBOUNCER_GLITCH_CNT_EN.
//
// state   | meaning
// ST_LOW  | accepted level is 0, waiting for a 1 on sync_q
// ST_RISE | qualifying a 0->1 change, cnt counts stable cycles
// ST_HIGH | accepted level is 1, waiting for a 0 on sync_q
// ST_FALL | qualifying a 1->0 change, cnt counts stable cycles
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  input  logic enable_i,
  output logic level_o,
  output logic busy_o
`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  ,
  output logic [GLITCH_CNT_W-1:0] glitch_count_o
`endif
);

  localparam int                    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam debounce_state_e       ST_RESET = RESET_VALUE ? ST_HIGH : ST_LOW;

  logic            sync_q;
  debounce_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            level_d;

  bit_synchronizer #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (async_i),
    .q_o   (sync_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_o;
    if (!enable_i) begin
      // Drop any qualification in progress; the next one starts from zero.
      cnt_d   = '0;
      state_d = level_o ? ST_HIGH : ST_LOW;
    end else begin
      case (state_q)
        ST_LOW: begin
          if (sync_q) begin
            state_d = ST_RISE;
            cnt_d   = '0;
          end
        end
        ST_RISE: begin
          if (!sync_q) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HIGH;
            level_d = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!sync_q) begin
            state_d = ST_FALL;
            cnt_d   = '0;
          end
        end
        ST_FALL: begin
          if (sync_q) begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_LOW;
            level_d = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      level_o <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_o <= level_d;
    end
  end

  assign busy_o = (state_q == ST_RISE) || (state_q == ST_FALL);

`ifdef INPUT_DEBOUNCER_GLITCH_CNT_EN
  logic                    glitch;
  logic [GLITCH_CNT_W-1:0] glitch_cnt_q;

  assign glitch = enable_i && (((state_q == ST_RISE) && !sync_q) ||
                               ((state_q == ST_FALL) &&  sync_q));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      glitch_cnt_q <= '0;
    end else if (glitch && (glitch_cnt_q != {GLITCH_CNT_W{1'b1}})) begin
      glitch_cnt_q <= glitch_cnt_q + 1'b1;
    end
  end

  assign glitch_count_o = glitch_cnt_q;
`endif

endmodule
